// File: rtl/apb_event_conditioner.sv
// Conditions asynchronous peripheral lines into clean pulses or levels for the event unit.
// Per line: synchronizer, glitch filter, edge/level select; configured over APB.
module apb_event_conditioner #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_WIDTH     = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      event_async_i,
    output logic [NUM_LINES-1:0]      event_o
);

    logic [2*NUM_LINES-1:0] mode_q;
    logic [FILT_WIDTH-1:0]  thr_q;
    logic [NUM_LINES-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_LINES-1:0]   raw_s;
    logic [NUM_LINES-1:0]   filt;
    logic [NUM_LINES-1:0]   filt_q;
    logic [FILT_WIDTH-1:0]  cnt [NUM_LINES];

    logic [1:0]  reg_sel;
    logic        addr_err;
    logic        wr_en;
    logic [63:0] mode_ext;
    logic [63:0] mode_wr;
    logic        unused_addr_bits;

    assign reg_sel          = PADDR[3:2];
    assign addr_err         = |PADDR[APB_ADDR_WIDTH-1:4];
    assign wr_en            = PSEL & PENABLE & PWRITE & ~addr_err;
    assign unused_addr_bits = ^PADDR[1:0];

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & addr_err & ~HRESET;

    // Both MODE registers viewed as one 64-bit space; fields of absent lines stay 0.
    always_comb begin
        mode_ext = '0;
        mode_ext[2*NUM_LINES-1:0] = mode_q;
        mode_wr = mode_ext;
        if (reg_sel == 2'd0) mode_wr[31:0]  = PWDATA;
        if (reg_sel == 2'd1) mode_wr[63:32] = PWDATA;
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !addr_err) begin
            case (reg_sel)
                2'd0: PRDATA = mode_ext[31:0];
                2'd1: PRDATA = mode_ext[63:32];
                2'd2: PRDATA[FILT_WIDTH-1:0] = thr_q;
                default: PRDATA[NUM_LINES-1:0] = filt;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mode_q <= '0;
            thr_q  <= '0;
        end else if (wr_en) begin
            if (reg_sel == 2'd0 || reg_sel == 2'd1) mode_q <= mode_wr[2*NUM_LINES-1:0];
            if (reg_sel == 2'd2) thr_q <= PWDATA[FILT_WIDTH-1:0];
        end
    end

    assign raw_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= event_async_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Compare uses >= so a threshold lowered mid-count commits on the next edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            filt   <= '0;
            filt_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) cnt[i] <= '0;
        end else begin
            filt_q <= filt;
            for (int i = 0; i < NUM_LINES; i++) begin
                if (raw_s[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= thr_q) begin
                    filt[i] <= raw_s[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            event_o <= '0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                case (mode_q[2*i +: 2])
                    2'b01:   event_o[i] <= filt[i] & ~filt_q[i];
                    2'b10:   event_o[i] <= ~filt[i] & filt_q[i];
                    2'b11:   event_o[i] <= filt[i];
                    default: event_o[i] <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_event_conditioner.sv
// Directed bench: drivers push expected responses, a negedge monitor pops and compares.
module tb_apb_event_conditioner;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] event_async_i;
    logic [31:0] event_o;

    logic [31:0] ev_exp_q[$];
    logic [33:0] apb_exp_q[$];  // {is_write, pslverr, prdata}
    int          n_total = 0;
    int          n_bad   = 0;

    apb_event_conditioner dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .event_async_i(event_async_i), .event_o(event_o)
    );

    always #5 HCLK = ~HCLK;

    // Drivers act 1 time unit after each rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    // Entry k is compared against event_o after the (k-1)th edge following this call.
    task automatic push_ev(input int n, input int lo, input int hi, input logic [31:0] val);
        for (int k = 0; k < n; k++) ev_exp_q.push_back((k >= lo && k <= hi) ? val : 32'h0);
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, input logic err);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        step();
        PENABLE = 1'b1;
        apb_exp_q.push_back({1'b1, err, 32'h0});
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, input logic [31:0] exp, input logic err);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        step();
        PENABLE = 1'b1;
        apb_exp_q.push_back({1'b0, err, exp});
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    always @(negedge HCLK) begin
        logic [31:0] ev_exp;
        logic [33:0] apb_exp;
        if (ev_exp_q.size() > 0) begin
            ev_exp = ev_exp_q.pop_front();
            n_total++;
            if (event_o !== ev_exp) begin
                n_bad++;
                $display("FAIL event_o @%0t: got %h expected %h", $time, event_o, ev_exp);
            end
        end
        if (PSEL && PENABLE) begin
            n_total++;
            if (PREADY !== 1'b1) begin
                n_bad++;
                $display("FAIL pready @%0t: got %b expected 1", $time, PREADY);
            end
            if (apb_exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL apb_unexpected @%0t: got access expected none", $time);
            end else begin
                apb_exp = apb_exp_q.pop_front();
                n_total++;
                if (PSLVERR !== apb_exp[32]) begin
                    n_bad++;
                    $display("FAIL pslverr addr=%h @%0t: got %b expected %b", PADDR, $time, PSLVERR, apb_exp[32]);
                end
                if (!apb_exp[33]) begin
                    n_total++;
                    if (PRDATA !== apb_exp[31:0]) begin
                        n_bad++;
                        $display("FAIL prdata addr=%h @%0t: got %h expected %h", PADDR, $time, PRDATA, apb_exp[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        event_async_i = 32'hFFFF_FFFF;

        // Reset with all lines high, registers read 0.
        step();
        push_ev(2, 1, 0, 32'h0);
        cycles(2);
        HRESET = 1'b0;
        apb_read(12'h000, 32'h0, 1'b0);
        apb_read(12'h004, 32'h0, 1'b0);
        apb_read(12'h008, 32'h0, 1'b0);
        apb_write(12'h000, 32'h3, 1'b0);
        cycles(2);
        push_ev(1, 0, 0, 32'h1);
        cycles(1);
        // Mid-operation reset clears event_o; held-high line re-detects as rising.
        HRESET = 1'b1;
        push_ev(2, 1, 0, 32'h0);
        cycles(2);
        HRESET = 1'b0;
        push_ev(7, 4, 4, 32'h1);
        apb_write(12'h000, 32'h1, 1'b0);
        cycles(5);
        apb_read(12'h00C, 32'hFFFF_FFFF, 1'b0);

        // Rising mode, thr=0: only the 0->1 transition pulses.
        event_async_i = 32'h0;
        push_ev(8, 1, 0, 32'h0);
        cycles(8);
        event_async_i = 32'h1;
        push_ev(8, 4, 4, 32'h1);
        cycles(8);
        event_async_i = 32'h0;
        push_ev(8, 1, 0, 32'h0);
        cycles(8);

        // Falling mode, thr=3: 3-cycle glitch rejected, 5-cycle low accepted.
        apb_write(12'h008, 32'h3, 1'b0);
        apb_write(12'h000, 32'h2, 1'b0);
        event_async_i = 32'h1;
        push_ev(10, 1, 0, 32'h0);
        cycles(10);
        event_async_i = 32'h0;
        push_ev(12, 1, 0, 32'h0);
        cycles(3);
        event_async_i = 32'h1;
        cycles(9);
        event_async_i = 32'h0;
        push_ev(12, 7, 7, 32'h1);
        cycles(5);
        event_async_i = 32'h1;
        cycles(7);
        push_ev(4, 1, 0, 32'h0);
        cycles(4);

        // Level mode on line 31, 10-cycle high.
        apb_write(12'h000, 32'h0, 1'b0);
        apb_write(12'h008, 32'h0, 1'b0);
        event_async_i = 32'h0;
        cycles(6);
        apb_write(12'h004, 32'hC000_0000, 1'b0);
        event_async_i = 32'h8000_0000;
        push_ev(16, 4, 13, 32'h8000_0000);
        cycles(5);
        apb_read(12'h00C, 32'h8000_0000, 1'b0);
        cycles(3);
        event_async_i = 32'h0;
        cycles(6);
        apb_read(12'h00C, 32'h0, 1'b0);
        apb_write(12'h004, 32'h0, 1'b0);

        // Register read-back and unmapped accesses.
        apb_write(12'h000, 32'hA5A5_A5A5, 1'b0);
        apb_read(12'h000, 32'hA5A5_A5A5, 1'b0);
        apb_write(12'h008, 32'hF, 1'b0);
        apb_read(12'h008, 32'hF, 1'b0);
        apb_write(12'h004, 32'h5A5A_5A5A, 1'b0);
        apb_read(12'h004, 32'h5A5A_5A5A, 1'b0);
        apb_write(12'h010, 32'h1234_5678, 1'b1);
        apb_read(12'h010, 32'h0, 1'b1);
        apb_write(12'h014, 32'hFFFF_FFFF, 1'b1);
        apb_write(12'h018, 32'h3, 1'b1);
        apb_read(12'h004, 32'h5A5A_5A5A, 1'b0);
        apb_read(12'h000, 32'hA5A5_A5A5, 1'b0);
        apb_read(12'h008, 32'hF, 1'b0);
        apb_write(12'h000, 32'h0, 1'b0);
        apb_write(12'h004, 32'h0, 1'b0);

        // Threshold shrink mid-count commits on the edge after the write.
        apb_write(12'h008, 32'hF, 1'b0);
        apb_write(12'h000, 32'h1, 1'b0);
        event_async_i = 32'h1;
        push_ev(18, 14, 14, 32'h1);
        cycles(10);
        apb_write(12'h008, 32'h2, 1'b0);
        cycles(6);

        cycles(2);
        n_total++;
        if (ev_exp_q.size() != 0 || apb_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queues_drained: got ev=%0d apb=%0d expected 0 0", ev_exp_q.size(), apb_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
